// File: rtl/i2s_frame_sequencer.sv
// I2S capture sequencer: gates the receiver, discards the mic settle period,
// packs samples into fixed-length frames in a ping-pong buffer and streams
// complete frames downstream over valid/ready.
module i2s_frame_sequencer #(
  parameter int DATA_W         = 16,
  parameter int FRAME_LEN      = 16,
  parameter int WARMUP_SAMPLES = 32,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_ovr,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid_in,
  output logic              i2s_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int WU_W  = (WARMUP_SAMPLES > 0) ? $clog2(WARMUP_SAMPLES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'((WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CAPTURE, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [1:0]        full;
  logic              wr_bank, rd_bank;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [WU_W-1:0]   wu_cnt;
  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  logic xfer, rd_free, cap_strobe, bank_blocked, wr_en, wr_last, drop, start, stop;
  logic [1:0] set_mask, clr_mask;

  // Handshake / write-acceptance decode. A bank being freed this cycle is
  // writable this cycle, so a read-side free beats a colliding strobe.
  always_comb begin
    xfer         = out_valid & out_ready;
    rd_free      = xfer & (rd_idx == IDX_LAST);
    cap_strobe   = (state == S_CAPTURE) & en & sample_valid_in;
    bank_blocked = full[wr_bank] & ~(rd_free & (rd_bank == wr_bank));
    wr_en        = cap_strobe & ~bank_blocked;
    drop         = cap_strobe & bank_blocked;
    wr_last      = wr_en & (wr_idx == IDX_LAST);
    start        = (state == S_IDLE) & en;
    stop         = ((state == S_WARMUP) | (state == S_CAPTURE)) & ~en;
    set_mask     = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    clr_mask     = rd_free ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (en) state_nxt = (WARMUP_SAMPLES == 0) ? S_CAPTURE : S_WARMUP;
      S_WARMUP: begin
        if (!en)                                        state_nxt = S_DRAIN;
        else if (sample_valid_in && (wu_cnt == WU_LAST)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: if (!en) state_nxt = S_DRAIN;
      S_DRAIN:   if (full == 2'b00) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Warmup counter, write pointer, bank flags, read pointer and frame count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wu_cnt      <= '0;
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      rd_idx      <= '0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      frame_count <= '0;
    end else begin
      if (start)
        wu_cnt <= '0;
      else if ((state == S_WARMUP) && en && sample_valid_in)
        wu_cnt <= wu_cnt + 1'b1;

      // Stopping throws away the partial frame; the bank itself stays put.
      if (stop)
        wr_idx <= '0;
      else if (wr_en)
        wr_idx <= wr_idx + 1'b1;
      if (wr_last) begin
        wr_bank     <= ~wr_bank;
        frame_count <= frame_count + 1'b1;
      end

      // Set and clear never target the same bank: a bank being written is not full.
      full <= (full & ~clr_mask) | set_mask;

      if (xfer)    rd_idx  <= rd_idx + 1'b1;
      if (rd_free) rd_bank <= ~rd_bank;
    end
  end

  // Sticky overrun and saturating drop counter; a drop beats a coincident clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clr_ovr)           drop_count <= CNT_W'(1);
      else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
    end else if (clr_ovr || start) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end
  end

  // Ping-pong sample storage, addressed {bank, index}
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= sample_in;
  end

  // Outputs; data is forced to zero when nothing is valid so reset shows zeros
  always_comb begin
    out_valid = full[rd_bank];
    out_data  = out_valid ? mem[{rd_bank, rd_idx}] : '0;
    out_last  = out_valid & (rd_idx == IDX_LAST);
    i2s_en    = (state == S_WARMUP) | (state == S_CAPTURE);
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Bench for i2s_frame_sequencer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_i2s_frame_sequencer;

  localparam int FL = 16;
  localparam int WU = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr_ovr = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid_in = 1'b0;
  logic        out_ready = 1'b1;
  logic        i2s_en, out_valid, out_last, busy, overrun;
  logic [15:0] out_data, drop_count, frame_count;

  int checks = 0;
  int errors = 0;

  i2s_frame_sequencer #(.DATA_W(16), .FRAME_LEN(FL), .WARMUP_SAMPLES(WU), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_ovr(clr_ovr),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .i2s_en(i2s_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun),
    .drop_count(drop_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 warmup, 2 capture, 3 drain. pend holds completed frames
  // back to back (oldest first); part is the frame being assembled.
  int          m_mode, m_wcnt, m_rpos, m_nfull;
  logic [15:0] pend[$];
  logic [15:0] part[$];
  logic [15:0] m_fcnt, m_dcnt;
  logic        m_ovr, m_xf, m_fr, m_drop, m_new;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_wcnt = 0; m_rpos = 0;
      pend.delete(); part.delete();
      m_fcnt = 0; m_dcnt = 0; m_ovr = 0;
    end else begin
      m_nfull = pend.size() / FL;
      m_xf    = (m_nfull > 0) && out_ready;
      m_fr    = m_xf && (m_rpos == FL - 1);
      m_drop  = 0;
      m_new   = 0;
      case (m_mode)
        0: if (en) begin
          m_mode = (WU == 0) ? 2 : 1; m_wcnt = 0; m_ovr = 0; m_dcnt = 0;
        end
        1: if (!en) m_mode = 3;
           else if (sample_valid_in) begin
             m_wcnt++;
             if (m_wcnt == WU) m_mode = 2;
           end
        2: if (!en) begin m_mode = 3; part.delete(); end
           else if (sample_valid_in) begin
             if (m_nfull == 2 && !m_fr) m_drop = 1;
             else begin
               part.push_back(sample_in);
               if (part.size() == FL) begin m_new = 1; m_fcnt++; end
             end
           end
        default: if (m_nfull == 0) m_mode = 0;
      endcase
      if (m_drop) begin
        m_ovr = 1;
        if (clr_ovr) m_dcnt = 1;
        else if (m_dcnt != 16'hFFFF) m_dcnt++;
      end else if (clr_ovr) begin
        m_ovr = 0; m_dcnt = 0;
      end
      if (m_xf) begin
        m_rpos++;
        if (m_rpos == FL) begin
          repeat (FL) void'(pend.pop_front());
          m_rpos = 0;
        end
      end
      if (m_new) begin
        foreach (part[i]) pend.push_back(part[i]);
        part.delete();
      end
    end
  end

  // Per-cycle comparison against the model; also logs accepted output words
  logic [15:0] log_q[$];
  logic        e_valid;
  always @(negedge clk) begin
    e_valid = (pend.size() >= FL);
    chk("out_valid",   out_valid, e_valid);
    chk("out_data",    out_data, e_valid ? pend[m_rpos] : 16'h0);
    chk("out_last",    out_last, e_valid && (m_rpos == FL - 1));
    chk("i2s_en",      i2s_en, (m_mode == 1) || (m_mode == 2));
    chk("busy",        busy, m_mode != 0);
    chk("overrun",     overrun, m_ovr);
    chk("drop_count",  drop_count, m_dcnt);
    chk("frame_count", frame_count, m_fcnt);
    if (out_valid && out_ready) log_q.push_back(out_data);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic sv, input logic [15:0] d);
    sample_valid_in = sv;
    sample_in       = d;
    @(posedge clk); #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0);
  endtask

  task automatic burst(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, base + 16'(i));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset i2s_en", i2s_en, 0);
    rst = 1'b1;
    idle(2);

    // Warmup discard + latency: samples 1..4 discarded, frame is 5..0x14
    en = 1'b1; out_ready = 1'b1;
    idle(1);
    burst(16'h0001, 19);
    chk("lat pre out_valid", out_valid, 0);
    cyc(1'b1, 16'h0014);
    chk("lat out_valid", out_valid, 1);
    chk("lat frame_count", frame_count, 1);
    chk("lat first data", out_data, 16'h0005);
    idle(20);
    chk("warm log size", log_q.size(), 16);
    chk("warm first", log_q[0], 16'h0005);
    chk("warm last", log_q[15], 16'h0014);

    // Backpressure overrun: 40 strobes, 2 frames fill, 8 dropped
    log_q.delete();
    out_ready = 1'b0;
    burst(16'h0100, 40);
    chk("ovr overrun", overrun, 1);
    chk("ovr drop_count", drop_count, 8);
    chk("ovr frame_count", frame_count, 3);
    out_ready = 1'b1;
    idle(40);
    burst(16'h0200, 16);
    idle(20);
    chk("ovr log size", log_q.size(), 48);
    chk("ovr log[0]", log_q[0], 16'h0100);
    chk("ovr log[31]", log_q[31], 16'h011F);
    chk("ovr third frame", log_q[32], 16'h0200);
    clr_ovr = 1'b1;
    idle(1);
    clr_ovr = 1'b0;
    chk("clr overrun", overrun, 0);
    chk("clr drop_count", drop_count, 0);

    // Stop mid-frame with frame 1 pending
    log_q.delete();
    out_ready = 1'b0;
    burst(16'h0300, 21);
    en = 1'b0;
    idle(1);
    chk("stop i2s_en", i2s_en, 0);
    chk("stop busy", busy, 1);
    out_ready = 1'b1;
    idle(20);
    chk("stop busy fell", busy, 0);
    chk("stop log size", log_q.size(), 16);
    chk("stop log last", log_q[15], 16'h030F);

    // Free/write collision: last read of a bank coincides with a strobe into it
    log_q.delete();
    en = 1'b1; out_ready = 1'b0;
    idle(1);
    burst(16'h00F0, WU);
    burst(16'h0400, 32);
    out_ready = 1'b1;
    idle(15);
    cyc(1'b1, 16'h04AA);
    chk("coll overrun", overrun, 0);
    burst(16'h04AB, 15);
    idle(20);
    chk("coll log size", log_q.size(), 48);
    chk("coll stored idx0", log_q[32], 16'h04AA);
    chk("coll frame end", log_q[47], 16'h04B9);

    // Reset mid-frame at rd_idx=7
    out_ready = 1'b0;
    burst(16'h0500, 16);
    out_ready = 1'b1;
    idle(7);
    rst = 1'b0; en = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst frame_count", frame_count, 0);
    chk("rst busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(3);
    log_q.delete();
    en = 1'b1;
    idle(1);
    burst(16'h00E0, WU);
    burst(16'h0600, 16);
    idle(20);
    chk("post-rst log size", log_q.size(), 16);
    chk("post-rst first", log_q[0], 16'h0600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_frame_sequencer.md
Name: i2s_frame_sequencer

Overview:
Controller that sequences the I2S receiver for the audio front end. It gates the receiver on and off and discards the microphone settle period. It packs received samples into fixed-length frames using a two-bank (ping-pong) buffer, then streams each complete frame downstream over a valid/ready handshake. It sits between the I2S receiver's sample/sample_valid outputs and the feature-extraction pipeline.

Parameters:
DATA_W, 16, sample width; matches the I2S receiver sample output.
FRAME_LEN, 16, samples per frame; power of two, at least 2.
WARMUP_SAMPLES, 32, samples discarded after each enable; 0 means no discard.
CNT_W, 16, width of the frame counter and the drop counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  level; 1 = capture requested
clr_ovr  in  1  single-cycle pulse; clears overrun and drop_count
sample_in  in  DATA_W  sample from the I2S receiver
sample_valid_in  in  1  one-cycle strobe from the I2S receiver
i2s_en  out  1  enable to the I2S receiver
out_data  out  DATA_W  frame sample to downstream
out_valid  out  1  out_data is valid
out_ready  in  1  downstream can accept
out_last  out  1  marks the final sample of a frame
busy  out  1  state is not IDLE
overrun  out  1  sticky; at least one sample was dropped
drop_count  out  CNT_W  number of dropped samples; saturates at all-ones
frame_count  out  CNT_W  number of completed frames written to a bank; wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Both bank-full flags 0; wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0, warmup counter=0.
- Frame write and stream-out (CAPTURE state; DRAIN and IDLE have no writes):
  - Each sample_valid_in writes sample_in into the write bank at wr_idx.
  - When wr_idx is FRAME_LEN-1: set full[wr_bank], toggle wr_bank, set wr_idx=0, increment frame_count.
  - Latency: the full flag is registered, so out_valid rises the cycle after the strobe that wrote the last sample.
- States:
  - IDLE: i2s_en=0. When en=1: go to WARMUP (or to CAPTURE if WARMUP_SAMPLES=0), set i2s_en=1 on the next edge, clear the warmup counter, clear overrun and drop_count.
  - WARMUP: i2s_en=1. Each sample_valid_in is discarded and counts. The strobe that brings the count to WARMUP_SAMPLES moves to CAPTURE; the first written sample is the next strobe.
  - CAPTURE: i2s_en=1. Frames are written as described above.
  - DRAIN: entered when en=0 in WARMUP or CAPTURE. i2s_en=0 on the next edge. The partial frame is discarded (wr_idx=0). Stays in DRAIN until both full flags are 0, then goes to IDLE. en=1 during DRAIN is ignored until IDLE is reached.
- Overrun:
  - A strobe in CAPTURE whose target bank is full[wr_bank]=1 (not yet drained) is dropped.
  - On a drop: wr_idx is unchanged, overrun=1, drop_count increments (saturating).
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_idx], taken combinationally from the buffer.
  - out_last = out_valid and rd_idx==FRAME_LEN-1.
  - A transfer occurs when out_valid=1 and out_ready=1; rd_idx increments.
  - On a transfer with out_last=1: clear full[rd_bank], toggle rd_bank, set rd_idx=0.
  - out_data and out_last must hold stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - A last-sample transfer that frees bank B in the same cycle as a strobe targeting B: the free wins and the sample is accepted (not dropped).
  - A last-sample write and a last-sample read in the same cycle update both flags independently.
  - clr_ovr coincident with a drop: the drop wins (overrun=1, drop_count=1).
- Width rules: wr_idx and rd_idx are clog2(FRAME_LEN) bits, and frame_count wraps naturally.

Test Plan:
- Warmup discard: WARMUP_SAMPLES=4; assert en, then send samples 0x0001..0x0014. Required: 0x0001–0x0004 are never output; the first frame is 0x0005..0x0014 with out_last on 0x0014; frame_count=1.
- Latency: out_ready=1; the strobe writing sample 16 of a frame at cycle t gives out_valid=1 at t+1; one sample is accepted per cycle; frame_count increments at t+1.
- Backpressure overrun: out_ready=0 for 40 strobes after warmup. Required: two frames fill, 8 samples are dropped, overrun=1, drop_count=8. Then set out_ready=1: 32 samples stream out in order and the third frame starts clean. clr_ovr then resets overrun and drop_count to 0.
- Stop mid-frame: deassert en after 5 samples of frame 2 while frame 1 is pending. Required: i2s_en falls on the next edge; frame 1 streams out fully; the 5 partial samples are never output; busy falls after frame 1's out_last transfer.
- Free/write collision: arrange the final read handshake of bank 0 to coincide with a strobe targeting bank 0. Required: the sample is stored at index 0 and overrun stays 0.
- Reset mid-frame: pull rst low during streaming at rd_idx=7. Required: all outputs are 0 immediately (asynchronous); after release state=IDLE and out_valid=0 until a new full frame is collected.
